// File: rtl/gpr_seq_ctrl.sv
// Command sequencer driving a 4-bit universal shift register (mode, parallel data, serial inputs).
// Optional feature macro: GPR_SEQ_ROTATE_EN enables ROR/ROL using the Q_fb feedback port.
module gpr_seq_ctrl (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    input  logic       cmd_fill,
    input  logic [3:0] Q_fb,
    output logic [1:0] S,
    output logic [3:0] X,
    output logic       r_in,
    output logic       l_in,
    output logic       done,
    output logic       busy
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] op_r;
    logic [3:0] data_r;
    logic       fill_r;
    logic [1:0] cnt_r;
    logic [2:0] op_dec_s;
    logic       multi_s;
    logic       accept_s;

`ifndef GPR_SEQ_ROTATE_EN
    logic       unused_q_fb_s;
    assign unused_q_fb_s = ^Q_fb;
`endif

    assign cmd_ready = (state_r != ST_EXEC);
    assign accept_s  = cmd_valid & cmd_ready;

    // Decode incoming opcode; rotates collapse to a single hold step when not built in
    always_comb begin
        op_dec_s = cmd_op;
`ifndef GPR_SEQ_ROTATE_EN
        if ((cmd_op == OP_ROR) || (cmd_op == OP_ROL)) begin
            op_dec_s = OP_NOP;
        end else begin
            op_dec_s = cmd_op;
        end
`endif
        case (op_dec_s)
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: multi_s = 1'b1;
            default:                        multi_s = 1'b0;
        endcase
    end

    // Next-state logic; cnt_r holds remaining steps minus one
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_r == 2'd0) state_nxt_s = ST_DONE;
                else               state_nxt_s = ST_EXEC;
            end
            ST_DONE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and command registers; CLR aborts any command in flight
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= ST_IDLE;
            op_r    <= OP_NOP;
            data_r  <= 4'b0000;
            fill_r  <= 1'b0;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r   <= op_dec_s;
                data_r <= cmd_data;
                fill_r <= cmd_fill;
                cnt_r  <= multi_s ? cmd_cnt : 2'd0;
            end else if ((state_r == ST_EXEC) && (cnt_r != 2'd0)) begin
                cnt_r  <= cnt_r - 2'd1;
            end else begin
                cnt_r  <= cnt_r;
            end
        end
    end

    // GPR control outputs from state and latched op; rotate serial bits come straight from Q_fb
    always_comb begin
        S    = 2'b00;
        X    = 4'b0000;
        r_in = 1'b0;
        l_in = 1'b0;
        done = (state_r == ST_DONE);
        busy = (state_r == ST_EXEC);
        if (state_r == ST_EXEC) begin
            case (op_r)
                OP_LOAD:  begin S = 2'b11; X = data_r; end
                OP_CLEAR: begin S = 2'b11; X = 4'b0000; end
                OP_SHR:   begin S = 2'b01; r_in = fill_r; end
                OP_SHL:   begin S = 2'b10; l_in = fill_r; end
`ifdef GPR_SEQ_ROTATE_EN
                OP_ROR:   begin S = 2'b01; r_in = Q_fb[0]; end
                OP_ROL:   begin S = 2'b10; l_in = Q_fb[3]; end
`endif
                default:  S = 2'b00;
            endcase
        end else begin
            S = 2'b00;
        end
    end

endmodule
